// File: rtl/fp_addsub_unit.sv
// fp_addsub_unit: multi-cycle IEEE-754 add/subtract (round-to-nearest-even) with valid/ready on both sides.
// Optional macro FPADD_FLAGS_EN adds the output_flags port {invalid, overflow, underflow, inexact}.
module fp_addsub_unit #(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [EXP_W+MAN_W:0]   input_a,
  input  logic [EXP_W+MAN_W:0]   input_b,
  input  logic                   input_op,
  input  logic                   input_valid,
  output logic                   input_ready,
  output logic [EXP_W+MAN_W:0]   output_z,
  output logic                   output_valid,
  input  logic                   output_ready
`ifdef FPADD_FLAGS_EN
  ,
  output logic [3:0]             output_flags
`endif
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int MW = MAN_W + 4;
  localparam logic signed [EW-1:0] BIAS = EW'((2 ** (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMIN = EW'(2 - (2 ** (EXP_W - 1)));
  localparam logic [W-1:0] QNAN = {1'b1, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_SPECIAL, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_PACK, S_DONE
  } state_t;

  function automatic logic is_nan(input logic [W-1:0] x);
    return (&x[W-2:MAN_W]) & (|x[MAN_W-1:0]);
  endfunction

  function automatic logic is_inf(input logic [W-1:0] x);
    return (&x[W-2:MAN_W]) & ~(|x[MAN_W-1:0]);
  endfunction

  function automatic logic is_zero(input logic [W-1:0] x);
    return ~(|x[W-2:0]);
  endfunction

  // Denormals share the minimum exponent and simply lack the hidden bit
  function automatic logic signed [EW-1:0] unpack_exp(input logic [W-1:0] x);
    return (x[W-2:MAN_W] == '0) ? EMIN : ($signed({2'b00, x[W-2:MAN_W]}) - BIAS);
  endfunction

  function automatic logic [MW-1:0] unpack_man(input logic [W-1:0] x);
    return {|x[W-2:MAN_W], x[MAN_W-1:0], 3'b000};
  endfunction

  function automatic logic [MW-1:0] shr_sticky(input logic [MW-1:0] m, input logic [EW-1:0] d);
    logic [EW-1:0] sh;
    logic [MW-1:0] mask;
    logic [MW-1:0] res;
    sh   = (d > EW'(MW)) ? EW'(MW) : d;
    mask = ~({MW{1'b1}} << sh);
    res  = m >> sh;
    res[0] = res[0] | (|(m & mask));
    return res;
  endfunction

  state_t                 state_r;
  logic [W-1:0]           a_r, b_r;
  logic signed [EW-1:0]   ea_r, eb_r, ez_r;
  logic [MW-1:0]          ma_r, mb_r, mz_r;
  logic                   sz_r;

  logic                   spec_hit_s;
  logic [W-1:0]           spec_z_s;
  logic [MW-1:0]          ma_al_s, mb_al_s;
  logic signed [EW-1:0]   e_al_s;
  logic [MW:0]            sum_s;
  logic                   mag_ge_s;
  logic [MW-1:0]          mag_diff_s;
  logic                   rnd_inc_s;
  logic [MAN_W+1:0]       rnd_sum_s;
  logic [EXP_W-1:0]       exp_field_s;

  // Special-case decode and per-stage arithmetic feeding the FSM
  always_comb begin
    spec_hit_s = 1'b1;
    spec_z_s   = '0;
    if (is_nan(a_r) || is_nan(b_r) || (is_inf(a_r) && is_inf(b_r) && (a_r[W-1] != b_r[W-1]))) begin
      spec_z_s = QNAN;
    end else if (is_inf(a_r)) begin
      spec_z_s = a_r;
    end else if (is_inf(b_r)) begin
      spec_z_s = b_r;
    end else if (is_zero(a_r) && is_zero(b_r)) begin
      spec_z_s = {a_r[W-1] & b_r[W-1], {(W-1){1'b0}}};
    end else if (is_zero(a_r)) begin
      spec_z_s = b_r;
    end else if (is_zero(b_r)) begin
      spec_z_s = a_r;
    end else begin
      spec_hit_s = 1'b0;
    end

    if (ea_r >= eb_r) begin
      ma_al_s = ma_r;
      mb_al_s = shr_sticky(mb_r, $unsigned(ea_r - eb_r));
      e_al_s  = ea_r;
    end else begin
      ma_al_s = shr_sticky(ma_r, $unsigned(eb_r - ea_r));
      mb_al_s = mb_r;
      e_al_s  = eb_r;
    end

    sum_s      = {1'b0, ma_r} + {1'b0, mb_r};
    mag_ge_s   = (ma_r >= mb_r);
    mag_diff_s = mag_ge_s ? (ma_r - mb_r) : (mb_r - ma_r);

    rnd_inc_s   = mz_r[2] & (mz_r[1] | mz_r[0] | mz_r[3]);
    rnd_sum_s   = {1'b0, mz_r[MW-1:3]} + {{(MAN_W+1){1'b0}}, rnd_inc_s};
    exp_field_s = EXP_W'(ez_r + BIAS);
  end

  // Control FSM and datapath registers; outputs are registered
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= S_IDLE;
      a_r          <= '0;
      b_r          <= '0;
      ea_r         <= '0;
      eb_r         <= '0;
      ez_r         <= '0;
      ma_r         <= '0;
      mb_r         <= '0;
      mz_r         <= '0;
      sz_r         <= 1'b0;
      input_ready  <= 1'b1;
      output_valid <= 1'b0;
      output_z     <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (input_valid) begin
            a_r         <= input_a;
            b_r         <= {input_b[W-1] ^ input_op, input_b[W-2:0]};
            input_ready <= 1'b0;
            state_r     <= S_SPECIAL;
          end
        end
        S_SPECIAL: begin
          ea_r <= unpack_exp(a_r);
          eb_r <= unpack_exp(b_r);
          ma_r <= unpack_man(a_r);
          mb_r <= unpack_man(b_r);
          if (spec_hit_s) begin
            output_z     <= spec_z_s;
            output_valid <= 1'b1;
            state_r      <= S_DONE;
          end else begin
            state_r <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          ma_r    <= ma_al_s;
          mb_r    <= mb_al_s;
          ez_r    <= e_al_s;
          state_r <= S_ADD;
        end
        S_ADD: begin
          if (a_r[W-1] == b_r[W-1]) begin
            sz_r <= a_r[W-1];
            if (sum_s[MW]) begin
              mz_r <= {sum_s[MW:2], sum_s[1] | sum_s[0]};
              ez_r <= ez_r + EW'(1);
            end else begin
              mz_r <= sum_s[MW-1:0];
            end
          end else if (mag_diff_s == '0) begin
            // Exact cancellation: park at minimum exponent so NORM exits at once
            sz_r <= 1'b0;
            mz_r <= '0;
            ez_r <= EMIN;
          end else begin
            sz_r <= mag_ge_s ? a_r[W-1] : b_r[W-1];
            mz_r <= mag_diff_s;
          end
          state_r <= S_NORM;
        end
        S_NORM: begin
          if (!mz_r[MW-1] && (ez_r > EMIN)) begin
            mz_r <= {mz_r[MW-2:0], 1'b0};
            ez_r <= ez_r - EW'(1);
          end else if (ez_r < EMIN) begin
            mz_r <= {1'b0, mz_r[MW-1:2], mz_r[1] | mz_r[0]};
            ez_r <= ez_r + EW'(1);
          end else begin
            state_r <= S_ROUND;
          end
        end
        S_ROUND: begin
          if (rnd_sum_s[MAN_W+1]) begin
            mz_r <= {1'b1, {(MW-1){1'b0}}};
            ez_r <= ez_r + EW'(1);
          end else begin
            mz_r <= {rnd_sum_s[MAN_W:0], 3'b000};
          end
          state_r <= S_PACK;
        end
        S_PACK: begin
          if (ez_r > BIAS) begin
            output_z <= {sz_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          end else if (mz_r == '0) begin
            output_z <= '0;
          end else if (!mz_r[MW-1]) begin
            output_z <= {sz_r, {EXP_W{1'b0}}, mz_r[MW-2:3]};
          end else begin
            output_z <= {sz_r, exp_field_s, mz_r[MW-2:3]};
          end
          output_valid <= 1'b1;
          state_r      <= S_DONE;
        end
        S_DONE: begin
          if (output_ready) begin
            output_valid <= 1'b0;
            input_ready  <= 1'b1;
            state_r      <= S_IDLE;
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

`ifdef FPADD_FLAGS_EN
  // Exception flags: cleared on accept, built up per stage, held with the result
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      output_flags <= 4'b0000;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (input_valid) output_flags <= 4'b0000;
        end
        S_SPECIAL: begin
          output_flags[3] <= ~is_nan(a_r) & ~is_nan(b_r) & is_inf(a_r) & is_inf(b_r) &
                             (a_r[W-1] != b_r[W-1]);
        end
        S_ROUND: begin
          output_flags[1] <= (|mz_r[2:0]) & ~mz_r[MW-1];
          output_flags[0] <= |mz_r[2:0];
        end
        S_PACK: begin
          output_flags[2] <= (ez_r > BIAS);
        end
        default: output_flags <= output_flags;
      endcase
    end
  end
`endif

endmodule
